// File: rtl/mmio_host_pkg.sv
// mmio_host_pkg
//   Shared types and constants for the host-side MMIO requester:
//   FSM state encoding, bus widths, and rsp_err bit positions.
package mmio_host_pkg;

    localparam int MMIO_ADDR_W = 16;
    localparam int MMIO_TID_W  = 9;
    localparam int MMIO_DATA_W = 64;

    // Bit positions inside rsp_err
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_MISALIGN = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } t_mmio_host_state;

    // 64-bit MMIO accesses must sit on an even DWORD address
    function automatic logic is_misaligned(input logic [MMIO_ADDR_W-1:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mmio_host_req_if.sv
// mmio_host_req_if
//   Bundles the requester's bus-facing signals.
//   cmd_*   : command port (valid/ready) from the host side
//   mmio_*  : request strobes, address, TID and write data toward the AFU
//   c2_*    : MMIO read-response channel coming back from the AFU
//   rsp_*   : completion port (valid/ready) back to the host side
//   Modport master is used by the requester, slave by whatever drives it.
interface mmio_host_req_if;
    import mmio_host_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [MMIO_ADDR_W-1:0] cmd_addr;
    logic [MMIO_DATA_W-1:0] cmd_wdata;

    logic                   mmio_wr_valid;
    logic                   mmio_rd_valid;
    logic [MMIO_ADDR_W-1:0] mmio_addr;
    logic [MMIO_TID_W-1:0]  mmio_tid;
    logic [MMIO_DATA_W-1:0] mmio_wdata;

    logic                   c2_rd_valid;
    logic [MMIO_TID_W-1:0]  c2_tid;
    logic [MMIO_DATA_W-1:0] c2_data;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_write;
    logic [MMIO_DATA_W-1:0] rsp_data;
    logic [1:0]             rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  c2_rd_valid, c2_tid, c2_data,
        input  rsp_ready,
        output cmd_ready,
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_write, rsp_data, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output c2_rd_valid, c2_tid, c2_data,
        output rsp_ready,
        input  cmd_ready,
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_write, rsp_data, rsp_err
    );

endinterface

// File: rtl/mmio_host_timer.sv
// mmio_host_timer
//   Read-timeout counter, only built when MMIO_HOST_TIMEOUT_EN is defined.
//   Ports: clk, rst (async, active-high), clear (zero the count),
//          enable (count this cycle), expired (this is the last allowed
//          enabled cycle).
//   Parameter TIMEOUT_CYCLES: number of enabled cycles before expiry.
`ifdef MMIO_HOST_TIMEOUT_EN
module mmio_host_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry is flagged while the count shows TIMEOUT_CYCLES-1 completed
    // cycles, so the waiting state lasts exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // Cycle counter: cleared before each wait, advanced while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expired = enable && (count == LAST_COUNT);

endmodule
`endif

// File: rtl/mmio_host_req.sv
// mmio_host_req
//   Host-side MMIO requester. Takes one 64-bit read/write command at a time,
//   issues the matching one-cycle MMIO strobe with a 9-bit TID, waits for the
//   TID-matched c2 read response, and returns a completion.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     bus (master)  cmd_*, mmio_*, c2_*, rsp_* signals (see mmio_host_req_if)
//     stale_cnt     saturating count of c2 responses that matched nothing
//   Parameter TIMEOUT_CYCLES (2..65535): read wait limit in cycles.
//   Build option MMIO_HOST_TIMEOUT_EN: when defined, reads are abandoned after
//   TIMEOUT_CYCLES wait cycles with rsp_err[0]; when undefined a read waits
//   indefinitely and rsp_err[0] is never set.
module mmio_host_req
    import mmio_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_host_req_if.master       bus,
    output logic [7:0]            stale_cnt
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("mmio_host_req: TIMEOUT_CYCLES must be within 2..65535");
    end

    t_mmio_host_state       state;
    t_mmio_host_state       state_next;

    logic                   write_q;
    logic [MMIO_TID_W-1:0]  tid;

    logic                   load_cmd;
    logic                   wr_valid_d;
    logic                   rd_valid_d;
    logic                   rsp_valid_d;
    logic                   rsp_write_d;
    logic [MMIO_DATA_W-1:0] rsp_data_d;
    logic [1:0]             rsp_err_d;

    logic                   c2_match;
    logic                   timed_out;

    // Only a response carrying the TID of the outstanding read, seen while
    // waiting, is accepted. Everything else on c2 is counted as stale.
    assign c2_match = bus.c2_rd_valid && (state == WAIT) && (bus.c2_tid == bus.mmio_tid);

`ifdef MMIO_HOST_TIMEOUT_EN
    mmio_host_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ISSUE),
        .enable  (state == WAIT),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of the registered outputs. Completion
    // fields hold their current values unless a transition rewrites them,
    // which keeps them stable while the consumer stalls.
    always_comb begin
        state_next  = state;
        load_cmd    = 1'b0;
        wr_valid_d  = 1'b0;
        rd_valid_d  = 1'b0;
        rsp_valid_d = bus.rsp_valid;
        rsp_write_d = bus.rsp_write;
        rsp_data_d  = bus.rsp_data;
        rsp_err_d   = bus.rsp_err;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (is_misaligned(bus.cmd_addr)) begin
                        // Rejected without touching the MMIO bus or the TID
                        state_next              = RESP;
                        rsp_valid_d             = 1'b1;
                        rsp_write_d             = bus.cmd_write;
                        rsp_data_d              = '0;
                        rsp_err_d               = '0;
                        rsp_err_d[ERR_MISALIGN] = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        load_cmd   = 1'b1;
                        wr_valid_d = bus.cmd_write;
                        rd_valid_d = !bus.cmd_write;
                    end
                end
            end

            ISSUE: begin
                if (write_q) begin
                    state_next  = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = '0;
                end else begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                // A matching response beats a simultaneous timeout
                if (c2_match) begin
                    state_next  = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_data_d  = bus.c2_data;
                    rsp_err_d   = '0;
                end else if (timed_out) begin
                    state_next             = RESP;
                    rsp_valid_d            = 1'b1;
                    rsp_write_d            = 1'b0;
                    rsp_data_d             = '0;
                    rsp_err_d              = '0;
                    rsp_err_d[ERR_TIMEOUT] = 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_next  = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output and datapath registers. The request fields are loaded at the
    // command handshake so they are valid together with the strobe in the
    // following cycle; the TID advances once per issued request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cmd_ready     <= 1'b1;
            bus.mmio_wr_valid <= 1'b0;
            bus.mmio_rd_valid <= 1'b0;
            bus.mmio_addr     <= '0;
            bus.mmio_tid      <= '0;
            bus.mmio_wdata    <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_write     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_err       <= '0;
            write_q           <= 1'b0;
            tid               <= '0;
        end else begin
            bus.cmd_ready     <= (state_next == IDLE);
            bus.mmio_wr_valid <= wr_valid_d;
            bus.mmio_rd_valid <= rd_valid_d;
            bus.rsp_valid     <= rsp_valid_d;
            bus.rsp_write     <= rsp_write_d;
            bus.rsp_data      <= rsp_data_d;
            bus.rsp_err       <= rsp_err_d;

            if (load_cmd) begin
                bus.mmio_addr  <= bus.cmd_addr;
                bus.mmio_wdata <= bus.cmd_wdata;
                bus.mmio_tid   <= tid;
                write_q        <= bus.cmd_write;
            end

            if (state == ISSUE) begin
                tid <= tid + 1'b1;
            end
        end
    end

    // Saturating count of responses that arrived outside WAIT or with the
    // wrong TID (including late ones after a timeout)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt <= '0;
        end else if (bus.c2_rd_valid && !c2_match && (stale_cnt != 8'hFF)) begin
            stale_cnt <= stale_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mmio_host_req.sv
// tb_mmio_host_req
//   Self-checking bench for mmio_host_req. A table of command records with
//   their expected completions is applied one by one; expected completions go
//   into a queue when a command is driven and are popped when the requester
//   completes. Hand-written sequences cover the read timeout (or the long
//   wait when MMIO_HOST_TIMEOUT_EN is undefined), back-to-back writes with
//   completion back-pressure and TID wrap, and reset during a pending read.
module tb_mmio_host_req;
    import mmio_host_pkg::*;

    localparam int TB_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] stale_cnt;

    mmio_host_req_if bus ();

    mmio_host_req #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stale_cnt (stale_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                   write;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_DATA_W-1:0] wdata;
        int                     mode;      // 0 plain, 1 wrong TID first, 2 response during ISSUE first
        int                     delay;     // cycles after the strobe cycle for the real response
        logic [MMIO_DATA_W-1:0] c2_data;
        int                     stall;     // cycles of rsp_ready low before accepting
        logic                   exp_write;
        logic [MMIO_DATA_W-1:0] exp_data;
        logic [1:0]             exp_err;
    } vec_t;

    typedef struct {
        logic                   write;
        logic [MMIO_DATA_W-1:0] data;
        logic [1:0]             err;
    } exp_t;

    vec_t  vecs[$];
    exp_t  rsp_q[$];
    int    total_cnt = 0;
    int    bad_cnt   = 0;
    logic [MMIO_TID_W-1:0] exp_tid = '0;
    int    exp_stale = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic driveC2(input logic v, input logic [MMIO_TID_W-1:0] t, input logic [63:0] d);
        bus.c2_rd_valid = v;
        bus.c2_tid      = t;
        bus.c2_data     = d;
    endtask

    task automatic waitCmdReady(output logic ok);
        int waited = 0;
        while (!bus.cmd_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = bus.cmd_ready;
        if (!ok) check("cmd_ready_wait", 64'd0, 64'd1);
    endtask

    // Drives one command and plays the responder for reads; returns at the
    // cycle where the completion is due.
    task automatic applyStimulus(input vec_t v);
        logic ok;
        exp_t e;
        logic [MMIO_TID_W-1:0] cur_tid;
        waitCmdReady(ok);
        if (!ok) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        e.write = v.exp_write;
        e.data  = v.exp_data;
        e.err   = v.exp_err;
        rsp_q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (v.addr[0]) begin
            check("misalign_no_wr", 64'(bus.mmio_wr_valid), 64'd0);
            check("misalign_no_rd", 64'(bus.mmio_rd_valid), 64'd0);
            @(negedge clk);
            check("misalign_no_rd2", 64'(bus.mmio_rd_valid | bus.mmio_wr_valid), 64'd0);
        end else begin
            check("wr_strobe", 64'(bus.mmio_wr_valid), 64'(v.write));
            check("rd_strobe", 64'(bus.mmio_rd_valid), 64'(!v.write));
            check("mmio_addr", 64'(bus.mmio_addr), 64'(v.addr));
            check("mmio_tid", 64'(bus.mmio_tid), 64'(exp_tid));
            if (v.write) check("mmio_wdata", bus.mmio_wdata, v.wdata);
            cur_tid = exp_tid;
            exp_tid = exp_tid + 1'b1;
            if (v.write) begin
                @(negedge clk);
            end else begin
                if (v.mode == 2) begin
                    driveC2(1'b1, cur_tid, 64'hBAD2);
                    exp_stale++;
                end
                for (int c = 1; c <= v.delay; c++) begin
                    @(negedge clk);
                    driveC2(1'b0, '0, '0);
                    if (c == v.delay) begin
                        driveC2(1'b1, cur_tid, v.c2_data);
                    end else begin
                        check("no_early_rsp", 64'(bus.rsp_valid), 64'd0);
                        if (c == 1 && v.mode == 1) begin
                            driveC2(1'b1, cur_tid ^ 9'h001, 64'hBAD1);
                            exp_stale++;
                        end
                    end
                end
                @(negedge clk);
                driveC2(1'b0, '0, '0);
            end
        end
    endtask

    // Compares the completion against the scoreboard, optionally stalls it,
    // then accepts it.
    task automatic checkOutput(input int stall);
        exp_t e;
        int   waited = 0;
        check("rsp_on_time", 64'(bus.rsp_valid), 64'd1);
        while (!bus.rsp_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (rsp_q.size() == 0) begin
            check("rsp_queue_nonempty", 64'd0, 64'd1);
            return;
        end
        e = rsp_q.pop_front();
        check("rsp_write", 64'(bus.rsp_write), 64'(e.write));
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check("stale_cnt", 64'(stale_cnt), 64'(exp_stale));
        check("strobes_low", 64'(bus.mmio_wr_valid | bus.mmio_rd_valid), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_data", bus.rsp_data, e.data);
            check("stall_err", 64'(bus.rsp_err), 64'(e.err));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
    endtask

`ifdef MMIO_HOST_TIMEOUT_EN
    task automatic runTimeout();
        logic ok;
        logic [MMIO_TID_W-1:0] cur_tid;
        waitCmdReady(ok);
        if (!ok) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0040;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("to_rd_strobe", 64'(bus.mmio_rd_valid), 64'd1);
        cur_tid = exp_tid;
        exp_tid = exp_tid + 1'b1;
        repeat (TB_TIMEOUT) @(negedge clk);
        check("to_not_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("to_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("to_rsp_data", bus.rsp_data, 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        driveC2(1'b1, cur_tid, 64'h1A7E);
        exp_stale++;
        @(negedge clk);
        driveC2(1'b0, '0, '0);
        @(negedge clk);
        check("to_late_stale", 64'(stale_cnt), 64'(exp_stale));
    endtask
`endif

    task automatic runBackToBack();
        int   issued = 0, done = 0, strobes = 0, cyc = 0, stall_left = 0, last_cyc = 0;
        logic stalled_this = 1'b0, wrap_seen = 1'b0;
        logic [MMIO_TID_W-1:0] prev_tid = '0;
        logic [63:0] wq[$];
        logic [63:0] w;
        exp_t snap, e, ex;
        bus.rsp_ready = 1'b1;
        while (done < 513 && cyc < 6000) begin
            if (bus.mmio_wr_valid) begin
                w = (wq.size() > 0) ? wq.pop_front() : 64'hX;
                check("b2b_tid", 64'(bus.mmio_tid), 64'(exp_tid));
                check("b2b_wdata", bus.mmio_wdata, w);
                if (strobes > 0 && prev_tid == 9'd511 && bus.mmio_tid == 9'd0) wrap_seen = 1'b1;
                if (strobes > 0 && strobes < 6) check("b2b_spacing", 64'(cyc - last_cyc), 64'd3);
                prev_tid = bus.mmio_tid;
                last_cyc = cyc;
                strobes++;
                exp_tid = exp_tid + 1'b1;
            end
            if (bus.rsp_valid) begin
                if (stall_left > 0) begin
                    check("b2b_hold_data", bus.rsp_data, snap.data);
                    check("b2b_hold_write", 64'(bus.rsp_write), 64'(snap.write));
                    stall_left--;
                    bus.rsp_ready = 1'b0;
                end else if (!stalled_this && ((done + 1) % 7 == 0)) begin
                    snap.write    = bus.rsp_write;
                    snap.data     = bus.rsp_data;
                    snap.err      = bus.rsp_err;
                    stalled_this  = 1'b1;
                    stall_left    = 4;
                    bus.rsp_ready = 1'b0;
                end else begin
                    bus.rsp_ready = 1'b1;
                    if (rsp_q.size() > 0) begin
                        e = rsp_q.pop_front();
                        check("b2b_rsp_write", 64'(bus.rsp_write), 64'(e.write));
                        check("b2b_rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end else begin
                        check("b2b_queue_nonempty", 64'd0, 64'd1);
                    end
                    done++;
                    stalled_this = 1'b0;
                end
            end else begin
                bus.rsp_ready = 1'b1;
            end
            if (issued < 513) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 16'h0020;
                bus.cmd_wdata = {32'(issued), 32'hC0DE_0000};
                if (bus.cmd_ready) begin
                    wq.push_back({32'(issued), 32'hC0DE_0000});
                    ex.write = 1'b1;
                    ex.data  = '0;
                    ex.err   = 2'b00;
                    rsp_q.push_back(ex);
                    issued++;
                end
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("b2b_all_done", 64'(done), 64'd513);
        check("b2b_tid_wrap", 64'(wrap_seen), 64'd1);
    endtask

    task automatic runResetAbort();
        logic ok;
        int   activity = 0;
        logic [MMIO_TID_W-1:0] cur_tid;
        vec_t v;
        waitCmdReady(ok);
        if (!ok) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0020;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("abort_rd_strobe", 64'(bus.mmio_rd_valid), 64'd1);
        cur_tid = exp_tid;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_tid_zero", 64'(bus.mmio_tid), 64'd0);
        check("abort_rsp_low", 64'(bus.rsp_valid), 64'd0);
        check("abort_stale_zero", 64'(stale_cnt), 64'd0);
        exp_tid   = '0;
        exp_stale = 0;
        rsp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mmio_wr_valid || bus.mmio_rd_valid || bus.rsp_valid) activity++;
        end
        check("abort_no_activity", 64'(activity), 64'd0);
        driveC2(1'b1, cur_tid, 64'hDEAD);
        exp_stale++;
        @(negedge clk);
        driveC2(1'b0, '0, '0);
        @(negedge clk);
        check("abort_late_stale", 64'(stale_cnt), 64'(exp_stale));
        v = '{1'b1, 16'h0020, 64'h0BAD_CAFE_0000_0001, 0, 0, 64'd0, 0, 1'b1, 64'd0, 2'b00};
        applyStimulus(v);
        checkOutput(v.stall);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        driveC2(1'b0, '0, '0);

        vecs.push_back('{1'b1, 16'h0020, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'd0, 1, 1'b1, 64'd0, 2'b00});
        vecs.push_back('{1'b0, 16'h0020, 64'd0, 0, 1, 64'hA5A5, 2, 1'b0, 64'hA5A5, 2'b00});
        vecs.push_back('{1'b0, 16'h0020, 64'd0, 1, 5, 64'h1111_2222_3333_4444, 0, 1'b0, 64'h1111_2222_3333_4444, 2'b00});
        vecs.push_back('{1'b0, 16'h0003, 64'd0, 0, 0, 64'd0, 1, 1'b0, 64'd0, 2'b10});
        vecs.push_back('{1'b0, 16'h0100, 64'd0, 2, 3, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00});
        vecs.push_back('{1'b1, 16'h0005, 64'h5555, 0, 0, 64'd0, 0, 1'b1, 64'd0, 2'b10});
        vecs.push_back('{1'b1, 16'h0002, 64'hFFFF_0000_FFFF_0000, 0, 0, 64'd0, 3, 1'b1, 64'd0, 2'b00});
        vecs.push_back('{1'b0, 16'h7FFE, 64'd0, 0, 2, 64'hCAFE_F00D, 0, 1'b0, 64'hCAFE_F00D, 2'b00});
`ifdef MMIO_HOST_TIMEOUT_EN
        vecs.push_back('{1'b0, 16'h0030, 64'd0, 0, TB_TIMEOUT, 64'h7777, 0, 1'b0, 64'h7777, 2'b00});
`else
        vecs.push_back('{1'b0, 16'h0030, 64'd0, 0, 20, 64'h7777, 0, 1'b0, 64'h7777, 2'b00});
`endif

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("reset_wr_valid", 64'(bus.mmio_wr_valid), 64'd0);
        check("reset_rd_valid", 64'(bus.mmio_rd_valid), 64'd0);
        check("reset_addr", 64'(bus.mmio_addr), 64'd0);
        check("reset_tid", 64'(bus.mmio_tid), 64'd0);
        check("reset_wdata", bus.mmio_wdata, 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_write", 64'(bus.rsp_write), 64'd0);
        check("reset_rsp_data", bus.rsp_data, 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset_stale", 64'(stale_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].stall);
        end

`ifdef MMIO_HOST_TIMEOUT_EN
        runTimeout();
`endif
        runBackToBack();
        runResetAbort();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
